fpga_top: RTL and testbench
===========================

Name: fpga_top

Overview:
- Top-level board wrapper, single clock domain on fpga_CLK (50 MHz).
- Generates VGA timing with a grid test pattern on the vga interface.
- Holds the SDRAM interface in a legal idle (NOP) state.
- Drives status LEDs and the auxiliary-clock select, and detects activity on the auxiliary clock input by sampling it as data.

Parameters:
- HDISP, 800, active pixels per line
- VDISP, 480, active lines per frame
- HFP, 40, horizontal front porch (pixels)
- HPULSE, 48, horizontal sync width (pixels)
- HBP, 40, horizontal back porch (pixels)
- VFP, 13, vertical front porch (lines)
- VPULSE, 3, vertical sync width (lines)
- VBP, 29, vertical back porch (lines)
- HB_DIV, 25_000_000, fpga_CLK cycles per LEDR0 toggle
- GRID, 16, grid pitch in pixels (power of two)

Ports:
- fpga_CLK, in, 1, system clock, 50 MHz
- fpga_NRST, in, 1, reset, asynchronous, active-low
- fpga_CLK_AUX, in, 1, 27 MHz auxiliary clock; sampled as data only, never used as a clock
- fpga_SW0, in, 1, switch
- fpga_SW1, in, 1, auxiliary clock enable request
- fpga_LEDR0..3, out, 1 each, status LEDs
- fpga_SEL_CLK_AUX, out, 1, enables the external auxiliary oscillator
- vga_ifm, interface (master modport), VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK, VGA_SYNC, VGA_R/G/B[7:0]
- sdram_ifm, interface (master modport), clk, cke, cs_n, ras_n, cas_n, we_n, sAddr, ba, sDQ (inout), dqm

Behaviour:
- Reset: fpga_NRST is asserted asynchronously and released through a 2-flop synchronizer. All registers use the synchronized reset.
- Reset values:
  - All LEDs 0; fpga_SEL_CLK_AUX 0.
  - VGA_HS and VGA_VS 1; VGA_BLANK 0; RGB 0; VGA_CLK 0.
  - Counters 0.
- fpga_SEL_CLK_AUX: registered copy of fpga_SW1, 1 cycle latency.
- LEDR0: toggles every HB_DIV fpga_CLK cycles.
- LEDR1 (auxiliary clock activity):
  - fpga_CLK_AUX passes through 2 synchronizer flops.
  - Any change between consecutive synchronized samples reloads a 6-bit timeout counter to 63.
  - LEDR1 = 1 while the counter is nonzero; the counter decrements otherwise.
  - A stopped auxiliary clock clears LEDR1 within 66 cycles.
- LEDR2: registered fpga_SW0.
- LEDR3: 1 once the synchronized reset is released.
- Pixel enable:
  - Toggles every fpga_CLK cycle, giving a 25 MHz pixel rate.
  - VGA_CLK is the registered inverse of the enable, so RGB/sync change on its falling edge.
- Horizontal counter:
  - hcnt runs 0..HTOT-1, with HTOT = HDISP+HFP+HPULSE+HBP, and advances on each pixel enable.
  - On wrap, vcnt advances, running 0..VTOT-1 with VTOT = VDISP+VFP+VPULSE+VBP, then wraps to 0.
- Sync and blank outputs, all registered, 1 pixel latency after the counters:
  - VGA_HS = 0 iff HDISP+HFP ≤ hcnt < HDISP+HFP+HPULSE.
  - VGA_VS = 0 iff VDISP+VFP ≤ vcnt < VDISP+VFP+VPULSE.
  - VGA_BLANK = 1 iff hcnt<HDISP and vcnt<VDISP.
  - VGA_SYNC = 0 constant.
- Pixel pattern:
  - Active area: RGB = 8'hFF each when hcnt%GRID==0 or vcnt%GRID==0, else 0.
  - Outside the active area: RGB = 0.
- SDRAM interface:
  - sdram clk = fpga_CLK; cke=1; cs_n=0; ras_n=cas_n=we_n=1 (NOP continuously).
  - sAddr=0; ba=0; dqm all ones; sDQ tri-stated (high-Z).
- Reset mid-frame: counters return to 0 immediately and outputs go to their reset values. The first line after release starts at hcnt=0, vcnt=0.

Test Plan:
- HDISP=160, VDISP=90, NRST 0→1 with SW1=1 → fpga_SEL_CLK_AUX=1 one cycle after sampling, and the 27 MHz auxiliary clock starts.
  - LEDR1=1 within 10 cycles of the first auxiliary edge.
  - LEDR3=1 two cycles after release.
- Same configuration:
  - HS low period = 48 pixel enables = 96 fpga_CLK cycles.
  - Line period = 288 pixels = 576 cycles.
  - VS low period = 3 lines = 1728 cycles.
  - Frame period = 135 lines = 77 760 cycles (1.5552 ms); 10 ms yields 6 complete frames.
- Pattern check at 160×90:
  - Pixels (0,y), (16,y), (x,0), (x,80) read FFFFFF.
  - Pixel (5,5) reads 000000.
  - With BLANK=0, RGB is always 0.
- Stop the auxiliary clock (SW1=0) → fpga_SEL_CLK_AUX=0 and LEDR1=0 within 66 cycles.
- Assert NRST low mid-line for 3 cycles → HS=VS=1, BLANK=0, LEDs 0.
  - After release, the first HS falling edge occurs 200 pixels (400 cycles) later.
- Throughout simulation, SDRAM signals hold NOP (cs_n=0, ras_n=cas_n=we_n=1, cke=1) and sDQ remains Z; the memory model reports no command errors.

Source files
------------

// File: rtl/fpga_top_if.sv
// Board-level VGA and SDRAM pin bundles.
// vga_if: DAC clock/sync/blank/RGB; sdram_if: SDR SDRAM command/address/data pins.

interface vga_if;
    logic       VGA_CLK;
    logic       VGA_HS;
    logic       VGA_VS;
    logic       VGA_BLANK;
    logic       VGA_SYNC;
    logic [7:0] VGA_R;
    logic [7:0] VGA_G;
    logic [7:0] VGA_B;

    modport master (
        output VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK, VGA_SYNC,
        output VGA_R, VGA_G, VGA_B
    );
    modport slave (
        input VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK, VGA_SYNC,
        input VGA_R, VGA_G, VGA_B
    );
endinterface

interface sdram_if;
    logic        clk;
    logic        cke;
    logic        cs_n;
    logic        ras_n;
    logic        cas_n;
    logic        we_n;
    logic [12:0] sAddr;
    logic [1:0]  ba;
    logic [1:0]  dqm;
    logic        dq_oe;
    logic [15:0] dq_o;
    wire  [15:0] sDQ;

    // The data pins are only driven while dq_oe is set.
    assign sDQ = dq_oe ? dq_o : 'z;

    modport master (
        output clk, cke, cs_n, ras_n, cas_n, we_n,
        output sAddr, ba, dqm, dq_oe, dq_o,
        inout  sDQ
    );
    modport slave (
        input clk, cke, cs_n, ras_n, cas_n, we_n,
        input sAddr, ba, dqm, dq_oe, dq_o,
        inout sDQ
    );
endinterface

// File: rtl/fpga_top.sv
// Board wrapper: VGA grid test pattern, idle SDRAM, status LEDs, aux clock detect.
// Ports: fpga_CLK/fpga_NRST, fpga_CLK_AUX (sampled), SW0/SW1, LEDR0..3, SEL_CLK_AUX, vga_ifm, sdram_ifm.

module fpga_top #(
    parameter int HDISP  = 800,
    parameter int VDISP  = 480,
    parameter int HFP    = 40,
    parameter int HPULSE = 48,
    parameter int HBP    = 40,
    parameter int VFP    = 13,
    parameter int VPULSE = 3,
    parameter int VBP    = 29,
    parameter int HB_DIV = 25_000_000,
    parameter int GRID   = 16
) (
    input  logic     fpga_CLK,
    input  logic     fpga_NRST,
    input  logic     fpga_CLK_AUX,
    input  logic     fpga_SW0,
    input  logic     fpga_SW1,
    output logic     fpga_LEDR0,
    output logic     fpga_LEDR1,
    output logic     fpga_LEDR2,
    output logic     fpga_LEDR3,
    output logic     fpga_SEL_CLK_AUX,
    vga_if.master    vga_ifm,
    sdram_if.master  sdram_ifm
);

    localparam int HTOT = HDISP + HFP + HPULSE + HBP;
    localparam int VTOT = VDISP + VFP + VPULSE + VBP;
    localparam int HW   = $clog2(HTOT);
    localparam int VW   = $clog2(VTOT);
    localparam int GW   = $clog2(GRID);
    localparam int HBW  = $clog2(HB_DIV);

    localparam logic [HW-1:0]  H_LAST = HW'(HTOT - 1);
    localparam logic [VW-1:0]  V_LAST = VW'(VTOT - 1);
    localparam logic [HW-1:0]  H_ACT  = HW'(HDISP);
    localparam logic [VW-1:0]  V_ACT  = VW'(VDISP);
    localparam logic [HW-1:0]  HS_ON  = HW'(HDISP + HFP);
    localparam logic [HW-1:0]  HS_OFF = HW'(HDISP + HFP + HPULSE);
    localparam logic [VW-1:0]  VS_ON  = VW'(VDISP + VFP);
    localparam logic [VW-1:0]  VS_OFF = VW'(VDISP + VFP + VPULSE);
    localparam logic [HBW-1:0] HB_END = HBW'(HB_DIV - 1);

    logic           rs1;
    logic           rst_s;
    logic [HBW-1:0] hb_cnt;
    logic [2:0]     aux_q;
    logic [5:0]     act_cnt;
    logic           pix_en;
    logic           vga_clk;
    logic [HW-1:0]  hcnt;
    logic [VW-1:0]  vcnt;
    logic           hs;
    logic           vs;
    logic           blank;
    logic [7:0]     pix;
    logic           active;
    logic           on_grid;

    // Reset asserts immediately, releases two clocks later.
    always_ff @(posedge fpga_CLK or negedge fpga_NRST) begin
        if (!fpga_NRST) begin
            rs1   <= 1'b0;
            rst_s <= 1'b0;
        end else begin
            rs1   <= 1'b1;
            rst_s <= rs1;
        end
    end

    always_ff @(posedge fpga_CLK or negedge rst_s) begin
        if (!rst_s) begin
            fpga_SEL_CLK_AUX <= 1'b0;
            fpga_LEDR0       <= 1'b0;
            fpga_LEDR2       <= 1'b0;
            hb_cnt           <= '0;
        end else begin
            fpga_SEL_CLK_AUX <= fpga_SW1;
            fpga_LEDR2       <= fpga_SW0;
            if (hb_cnt == HB_END) begin
                hb_cnt     <= '0;
                fpga_LEDR0 <= ~fpga_LEDR0;
            end else begin
                hb_cnt <= hb_cnt + HBW'(1);
            end
        end
    end

    // aux_q[1] is the synchronized sample, aux_q[2] the one before it.
    always_ff @(posedge fpga_CLK or negedge rst_s) begin
        if (!rst_s) begin
            aux_q   <= '0;
            act_cnt <= '0;
        end else begin
            aux_q <= {aux_q[1:0], fpga_CLK_AUX};
            if (aux_q[2] ^ aux_q[1]) begin
                act_cnt <= 6'd63;
            end else if (act_cnt != '0) begin
                act_cnt <= act_cnt - 6'd1;
            end
        end
    end

    assign fpga_LEDR1 = (act_cnt != '0);
    assign fpga_LEDR3 = rst_s;

    assign active  = (hcnt < H_ACT) && (vcnt < V_ACT);
    assign on_grid = (hcnt[GW-1:0] == '0) || (vcnt[GW-1:0] == '0);

    // Counters and outputs move together on pix_en; VGA_CLK falls there.
    always_ff @(posedge fpga_CLK or negedge rst_s) begin
        if (!rst_s) begin
            pix_en  <= 1'b0;
            vga_clk <= 1'b0;
            hcnt    <= '0;
            vcnt    <= '0;
            hs      <= 1'b1;
            vs      <= 1'b1;
            blank   <= 1'b0;
            pix     <= '0;
        end else begin
            pix_en  <= ~pix_en;
            vga_clk <= ~pix_en;
            if (pix_en) begin
                if (hcnt == H_LAST) begin
                    hcnt <= '0;
                    vcnt <= (vcnt == V_LAST) ? '0 : vcnt + VW'(1);
                end else begin
                    hcnt <= hcnt + HW'(1);
                end
                hs    <= !((hcnt >= HS_ON) && (hcnt < HS_OFF));
                vs    <= !((vcnt >= VS_ON) && (vcnt < VS_OFF));
                blank <= active;
                pix   <= (active && on_grid) ? 8'hFF : 8'h00;
            end
        end
    end

    assign vga_ifm.VGA_CLK   = vga_clk;
    assign vga_ifm.VGA_HS    = hs;
    assign vga_ifm.VGA_VS    = vs;
    assign vga_ifm.VGA_BLANK = blank;
    assign vga_ifm.VGA_SYNC  = 1'b0;
    assign vga_ifm.VGA_R     = pix;
    assign vga_ifm.VGA_G     = pix;
    assign vga_ifm.VGA_B     = pix;

    // SDRAM parked on NOP with the data bus released.
    assign sdram_ifm.clk   = fpga_CLK;
    assign sdram_ifm.cke   = 1'b1;
    assign sdram_ifm.cs_n  = 1'b0;
    assign sdram_ifm.ras_n = 1'b1;
    assign sdram_ifm.cas_n = 1'b1;
    assign sdram_ifm.we_n  = 1'b1;
    assign sdram_ifm.sAddr = '0;
    assign sdram_ifm.ba    = '0;
    assign sdram_ifm.dqm   = '1;
    assign sdram_ifm.dq_oe = 1'b0;
    assign sdram_ifm.dq_o  = '0;

endmodule

// File: tb/tb_fpga_top.sv
// Directed bench for fpga_top at 160x90 with a short heartbeat divider.
// Drives clock, aux clock, switches and reset; checks LEDs, VGA timing/pattern, SDRAM idle.

`timescale 1ns/100ps

module tb_fpga_top;

    logic clk  = 1'b0;
    logic nrst = 1'b1;
    logic aux  = 1'b0;
    logic sw0  = 1'b0;
    logic sw1  = 1'b0;
    logic led0, led1, led2, led3, sel;
    bit   aux_run = 1'b0;

    int total = 0;
    int bad   = 0;
    int cur   = 0;
    int rises = 0;
    bit rose  = 1'b0;
    logic bq  = 1'b0;
    int cyc   = 0;

    vga_if   vga();
    sdram_if sdram();

    fpga_top #(
        .HDISP(160), .VDISP(90), .HB_DIV(20)
    ) u_dut (
        .fpga_CLK         (clk),
        .fpga_NRST        (nrst),
        .fpga_CLK_AUX     (aux),
        .fpga_SW0         (sw0),
        .fpga_SW1         (sw1),
        .fpga_LEDR0       (led0),
        .fpga_LEDR1       (led1),
        .fpga_LEDR2       (led2),
        .fpga_LEDR3       (led3),
        .fpga_SEL_CLK_AUX (sel),
        .vga_ifm          (vga),
        .sdram_ifm        (sdram)
    );

    always #10 clk = ~clk;

    initial forever begin
        #18.5;
        if (aux_run) aux = ~aux;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Line counter: first BLANK rise after reset release is line 0.
    always @(posedge clk) begin
        #2;
        rose = vga.VGA_BLANK && !bq;
        bq   = vga.VGA_BLANK;
        if (!nrst) rises = 0;
        else if (rose) rises++;
    end

    always @(negedge clk) begin
        cyc++;
        if (cyc % 13 == 0) begin
            chk("sdram_ctl",
                {29'd0, sdram.cke, sdram.cs_n, sdram.ras_n},
                {29'd0, 3'b101});
            chk("sdram_cmd",
                {29'd0, sdram.cas_n, sdram.we_n, sdram.dq_oe},
                {29'd0, 3'b110});
            chk("sdram_addr", {15'd0, sdram.sAddr, sdram.ba, sdram.dqm},
                32'h3);
            chk("sdram_clk", {31'd0, sdram.clk}, {31'd0, clk});
            chk("vga_sync", {31'd0, vga.VGA_SYNC}, 32'd0);
            if (!vga.VGA_BLANK)
                chk("blank_rgb", {8'd0, vga.VGA_R, vga.VGA_G, vga.VGA_B}, 32'd0);
        end
    end

    task automatic goto_line(input int y);
        bit f = 1'b0;
        for (int n = 0; n < 80000; n++) begin
            @(negedge clk);
            if (rose && rises == y + 1) begin
                f = 1'b1;
                break;
            end
        end
        chk($sformatf("line%0d_found", y), {31'd0, f}, 32'd1);
        cur = 0;
    endtask

    task automatic px(input int x, input logic [23:0] exp, input string tag);
        repeat (2 * (x - cur)) @(negedge clk);
        cur = x;
        chk(tag, {8'd0, vga.VGA_R, vga.VGA_G, vga.VGA_B}, {8'd0, exp});
    endtask

    initial begin
        int  n;
        int  n_hi;
        bit  f;
        logic l0;

        sw0 = 1'b1;
        sw1 = 1'b1;
        repeat (3) @(negedge clk);
        nrst = 1'b0;
        repeat (4) @(negedge clk);

        chk("rst_leds", {27'd0, led0, led1, led2, led3, sel}, 32'd0);
        chk("rst_hs_vs", {30'd0, vga.VGA_HS, vga.VGA_VS}, 32'd3);
        chk("rst_blank_clk", {30'd0, vga.VGA_BLANK, vga.VGA_CLK}, 32'd0);
        chk("rst_rgb", {8'd0, vga.VGA_R, vga.VGA_G, vga.VGA_B}, 32'd0);

        nrst = 1'b1;
        @(negedge clk);
        chk("led3_1cyc", {31'd0, led3}, 32'd0);
        @(negedge clk);
        chk("led3_2cyc", {31'd0, led3}, 32'd1);
        @(negedge clk);
        chk("sel_on", {31'd0, sel}, 32'd1);
        chk("led2_sw0", {31'd0, led2}, 32'd1);

        goto_line(0);
        chk("blank_x0", {31'd0, vga.VGA_BLANK}, 32'd1);
        px(0,   24'hFFFFFF, "px_0_0");
        px(5,   24'hFFFFFF, "px_5_0");
        px(16,  24'hFFFFFF, "px_16_0");
        px(159, 24'hFFFFFF, "px_159_0");
        px(160, 24'h000000, "px_160_0");
        chk("blank_x160", {31'd0, vga.VGA_BLANK}, 32'd0);

        chk("led1_idle", {31'd0, led1}, 32'd0);
        aux_run = 1'b1;
        f = 1'b0;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            if (led1) begin
                f = 1'b1;
                break;
            end
        end
        chk("led1_on", {31'd0, f}, 32'd1);

        goto_line(5);
        px(0,  24'hFFFFFF, "px_0_5");
        px(5,  24'h000000, "px_5_5");
        px(16, 24'hFFFFFF, "px_16_5");
        px(17, 24'h000000, "px_17_5");
        px(32, 24'hFFFFFF, "px_32_5");
        goto_line(16);
        px(7,  24'hFFFFFF, "px_7_16");
        goto_line(80);
        px(5,  24'hFFFFFF, "px_5_80");
        px(99, 24'hFFFFFF, "px_99_80");
        goto_line(89);
        px(5,  24'h000000, "px_5_89");
        px(48, 24'hFFFFFF, "px_48_89");

        f = 1'b0;
        for (int i = 0; i < 1200; i++) begin
            @(negedge clk);
            if (!vga.VGA_HS) begin
                f = 1'b1;
                break;
            end
        end
        chk("hs_fall_found", {31'd0, f}, 32'd1);
        n = 0;
        n_hi = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            n++;
            if (vga.VGA_HS && n_hi == 0) n_hi = n;
            if (!vga.VGA_HS && n_hi != 0) break;
        end
        chk("hs_low_cycles", n_hi, 96);
        chk("line_cycles", n, 576);

        l0 = led0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (led0 != l0) break;
        end
        l0 = led0;
        n = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            n++;
            if (led0 != l0) break;
        end
        chk("led0_period", n, 20);

        f = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (!vga.VGA_VS) begin
                f = 1'b1;
                break;
            end
        end
        chk("vs_fall_found", {31'd0, f}, 32'd1);
        n = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            n++;
            if (vga.VGA_VS) break;
        end
        chk("vs_low_cycles", n, 1728);

        aux_run = 1'b0;
        sw1 = 1'b0;
        @(negedge clk);
        chk("sel_off", {31'd0, sel}, 32'd0);
        n = 1;
        repeat (29) @(negedge clk);
        n = 30;
        chk("led1_holds", {31'd0, led1}, 32'd1);
        for (int i = 0; i < 80; i++) begin
            if (!led1) break;
            @(negedge clk);
            n++;
        end
        chk($sformatf("led1_timeout n=%0d", n),
            {31'd0, (n >= 60 && n <= 66)}, 32'd1);

        repeat (100) @(negedge clk);
        nrst = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_rst_hs_vs", {30'd0, vga.VGA_HS, vga.VGA_VS}, 32'd3);
        chk("mid_rst_blank", {31'd0, vga.VGA_BLANK}, 32'd0);
        chk("mid_rst_rgb", {8'd0, vga.VGA_R, vga.VGA_G, vga.VGA_B}, 32'd0);
        chk("mid_rst_leds", {27'd0, led0, led1, led2, led3, sel}, 32'd0);

        nrst = 1'b1;
        n = 0;
        for (int i = 0; i < 700; i++) begin
            @(negedge clk);
            n++;
            if (!vga.VGA_HS) break;
        end
        chk($sformatf("hs_after_rst n=%0d", n),
            {31'd0, (n >= 400 && n <= 406)}, 32'd1);
        chk("rise_after_rst", rises, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
